// File: rtl/controle_tranca_if.sv
// Signal bundle between the keypad/button logic and the lock sequencer.
// req_interno/req_senha are single-cycle pulses with no ready: the sequencer samples them on every edge and never stalls the source.
interface controle_tranca_if #(
  parameter int TIMER_W = 7
);
  logic               sensor_contato;
  logic               req_interno;
  logic               req_senha;
  logic               botao_bloqueio;
  logic [TIMER_W-1:0] timer_trancamento;
  logic [TIMER_W-1:0] timer_bip;
  logic               bip_habilitado;
  logic               tranca;
  logic               bip;
  logic [1:0]         estado;
  logic [1:0]         origem;
  logic               rejeitado;

  modport master (
    output sensor_contato, req_interno, req_senha, botao_bloqueio,
           timer_trancamento, timer_bip, bip_habilitado,
    input  tranca, bip, estado, origem, rejeitado
  );

  modport slave (
    input  sensor_contato, req_interno, req_senha, botao_bloqueio,
           timer_trancamento, timer_bip, bip_habilitado,
    output tranca, bip, estado, origem, rejeitado
  );
endinterface

// File: rtl/controle_tranca.sv
// Lock sequencer: arbitrates unlock requests, runs the auto-lock timer and
// raises the door-open alarm. estado doubles as the FSM debug view.
module controle_tranca #(
  parameter int UM_SEGUNDO = 1000,
  parameter int TIMER_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  controle_tranca_if.slave  bus
);

  typedef enum logic [1:0] {
    TRAVADO    = 2'b00,
    DESTRAVADO = 2'b01,
    ABERTO     = 2'b10
  } estado_t;

  localparam int                 PW      = (UM_SEGUNDO > 1) ? $clog2(UM_SEGUNDO) : 1;
  localparam logic [PW-1:0]      PRE_MAX = PW'(UM_SEGUNDO - 1);
  localparam logic [TIMER_W-1:0] SEG_MAX = '1;

  estado_t            r_estado, w_prox_estado;
  logic               r_tranca, r_bip, r_rejeitado;
  logic [1:0]         r_origem, w_prox_origem;
  logic [PW-1:0]      r_prescaler, w_prox_prescaler;
  logic [TIMER_W-1:0] r_segundos, w_prox_segundos;
  logic [TIMER_W-1:0] r_lim, w_prox_lim;
  logic               w_entrada, w_seg_tick, w_timeout, w_senha_ok;
  logic               w_prox_bip, w_prox_rejeitado;

  assign w_seg_tick = (r_prescaler == PRE_MAX);
  // The tick that would make seconds reach lim is exactly lim*UM_SEGUNDO cycles after entry.
  assign w_timeout  = w_seg_tick && (r_segundos == r_lim - TIMER_W'(1));
  assign w_senha_ok = bus.req_senha && !bus.botao_bloqueio;

  always_comb begin
    w_prox_estado = r_estado;
    w_prox_origem = r_origem;
    w_entrada     = 1'b0;
    case (r_estado)
      TRAVADO: begin
        if (!bus.sensor_contato) begin
          w_prox_estado = ABERTO;
          w_entrada     = 1'b1;
        end else if (bus.req_interno) begin
          w_prox_estado = DESTRAVADO;
          w_prox_origem = 2'b01;
          w_entrada     = 1'b1;
        end else if (w_senha_ok) begin
          w_prox_estado = DESTRAVADO;
          w_prox_origem = 2'b10;
          w_entrada     = 1'b1;
        end
      end
      DESTRAVADO: begin
        if (!bus.sensor_contato) begin
          w_prox_estado = ABERTO;
          w_entrada     = 1'b1;
        end else if (w_timeout) begin
          w_prox_estado = TRAVADO;
          w_entrada     = 1'b1;
        end else if (bus.req_interno) begin
          w_prox_origem = 2'b01;
          w_entrada     = 1'b1;
        end else if (w_senha_ok) begin
          w_prox_origem = 2'b10;
          w_entrada     = 1'b1;
        end
      end
      ABERTO: begin
        if (bus.sensor_contato) begin
          w_prox_estado = DESTRAVADO;
          w_entrada     = 1'b1;
        end
      end
      default: begin
        w_prox_estado = TRAVADO;
        w_entrada     = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_prox_lim = r_lim;
    if (w_entrada && (w_prox_estado == DESTRAVADO)) begin
      w_prox_lim = (bus.timer_trancamento == '0) ? TIMER_W'(1) : bus.timer_trancamento;
    end
  end

  always_comb begin
    w_prox_prescaler = r_prescaler + PW'(1);
    w_prox_segundos  = r_segundos;
    if (w_entrada) begin
      w_prox_prescaler = '0;
      w_prox_segundos  = '0;
    end else if (w_seg_tick) begin
      w_prox_prescaler = '0;
      if (r_segundos != SEG_MAX) w_prox_segundos = r_segundos + TIMER_W'(1);
    end
  end

  // Alarm and reject pulse are computed from next-state values so the registers line up with estado.
  assign w_prox_bip       = (w_prox_estado == ABERTO) && bus.bip_habilitado &&
                            (w_prox_segundos >= bus.timer_bip);
  assign w_prox_rejeitado = bus.req_senha && bus.botao_bloqueio &&
                            !(bus.req_interno && (r_estado != ABERTO));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado    <= TRAVADO;
      r_tranca    <= 1'b1;
      r_bip       <= 1'b0;
      r_origem    <= 2'b00;
      r_rejeitado <= 1'b0;
      r_prescaler <= '0;
      r_segundos  <= '0;
      r_lim       <= TIMER_W'(1);
    end else begin
      r_estado    <= w_prox_estado;
      r_tranca    <= (w_prox_estado == TRAVADO);
      r_bip       <= w_prox_bip;
      r_origem    <= w_prox_origem;
      r_rejeitado <= w_prox_rejeitado;
      r_prescaler <= w_prox_prescaler;
      r_segundos  <= w_prox_segundos;
      r_lim       <= w_prox_lim;
    end
  end

  assign bus.tranca    = r_tranca;
  assign bus.bip       = r_bip;
  assign bus.estado    = r_estado;
  assign bus.origem    = r_origem;
  assign bus.rejeitado = r_rejeitado;

endmodule

// File: tb/tb_controle_tranca.sv
// Bench for controle_tranca: directed scenarios with literal expectations, then
// random traffic, all compared every cycle against an elapsed-time model.
module tb_controle_tranca;

  localparam int UM = 10;
  localparam int TW = 7;

  logic clk = 1'b0;
  logic rst;

  controle_tranca_if #(.TIMER_W(TW)) bus ();

  controle_tranca #(.UM_SEGUNDO(UM), .TIMER_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state 0 locked, 1 unlocked, 2 open; m_k = cycles since last state entry.
  int m_state, m_k, m_lim, m_origem, m_segs;
  bit m_bip, m_rej;
  bit m_valid = 1'b0;

  task automatic m_enter(input int s);
    m_state = s;
    m_k     = 0;
    if (s == 1) m_lim = (bus.timer_trancamento == 0) ? 1 : int'(bus.timer_trancamento);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_k = 0; m_origem = 0; m_lim = 1; m_bip = 0; m_rej = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_rej = bus.req_senha && bus.botao_bloqueio && !(bus.req_interno && m_state != 2);
      case (m_state)
        0: begin
          if (!bus.sensor_contato) m_enter(2);
          else if (bus.req_interno) begin m_enter(1); m_origem = 1; end
          else if (bus.req_senha && !bus.botao_bloqueio) begin m_enter(1); m_origem = 2; end
          else m_k++;
        end
        1: begin
          if (!bus.sensor_contato) m_enter(2);
          else if (m_k + 1 == m_lim * UM) m_enter(0);
          else if (bus.req_interno) begin m_enter(1); m_origem = 1; end
          else if (bus.req_senha && !bus.botao_bloqueio) begin m_enter(1); m_origem = 2; end
          else m_k++;
        end
        default: begin
          if (bus.sensor_contato) m_enter(1);
          else m_k++;
        end
      endcase
      m_segs = (m_k / UM > 127) ? 127 : m_k / UM;
      m_bip  = (m_state == 2) && bus.bip_habilitado && (m_segs >= int'(bus.timer_bip));
    end
    #1;
    if (m_valid) begin
      check("tranca",    bus.tranca,    32'(m_state == 0));
      check("bip",       bus.bip,       32'(m_bip));
      check("estado",    bus.estado,    32'(m_state));
      check("origem",    bus.origem,    32'(m_origem));
      check("rejeitado", bus.rejeitado, 32'(m_rej));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input bit a_interno, input bit a_senha);
    bus.req_interno = a_interno;
    bus.req_senha   = a_senha;
    @(negedge clk);
    bus.req_interno = 1'b0;
    bus.req_senha   = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst                   = 1'b1;
    bus.sensor_contato    = 1'b1;
    bus.req_interno       = 1'b0;
    bus.req_senha         = 1'b0;
    bus.botao_bloqueio    = 1'b0;
    bus.timer_trancamento = 7'd5;
    bus.timer_bip         = 7'd2;
    bus.bip_habilitado    = 1'b0;

    // 1: reset
    wait_cyc(3);
    rst = 1'b0;
    check("T1 tranca", bus.tranca, 1);
    check("T1 estado", bus.estado, 0);
    check("T1 origem", bus.origem, 0);

    // 2: auto-lock after 5 s = 50 cycles
    pulse(1, 0);
    check("T2 unlock tranca", bus.tranca, 0);
    check("T2 origem", bus.origem, 1);
    wait_cyc(37);
    check("T2 tranca@37", bus.tranca, 0);
    wait_cyc(12);
    check("T2 tranca@49", bus.tranca, 0);
    wait_cyc(1);
    check("T2 tranca@50", bus.tranca, 1);
    check("T2 estado@50", bus.estado, 0);

    // 3: opening abandons the count, closing restarts it
    pulse(1, 0);
    wait_cyc(30);
    bus.sensor_contato = 1'b0;
    wait_cyc(1);
    check("T3 open estado", bus.estado, 2);
    check("T3 open tranca", bus.tranca, 0);
    wait_cyc(4);
    bus.sensor_contato = 1'b1;
    wait_cyc(1);
    check("T3 close estado", bus.estado, 1);
    wait_cyc(20);
    check("T3 tranca@20", bus.tranca, 0);
    wait_cyc(29);
    check("T3 tranca@49", bus.tranca, 0);
    wait_cyc(1);
    check("T3 tranca@50", bus.tranca, 1);

    // 4: blocked password
    bus.botao_bloqueio = 1'b1;
    pulse(0, 1);
    check("T4 rejeitado", bus.rejeitado, 1);
    check("T4 tranca", bus.tranca, 1);
    wait_cyc(1);
    check("T4 rejeitado drop", bus.rejeitado, 0);

    // 5: simultaneous requests, interno wins
    bus.botao_bloqueio = 1'b0;
    pulse(1, 1);
    check("T5 origem", bus.origem, 1);
    check("T5 rejeitado", bus.rejeitado, 0);
    check("T5 tranca", bus.tranca, 0);
    wait_cyc(50);
    check("T5 relock", bus.tranca, 1);

    // 6: door-open alarm and reset mid-count
    bus.timer_bip      = 7'd2;
    bus.bip_habilitado = 1'b1;
    pulse(1, 0);
    bus.sensor_contato = 1'b0;
    wait_cyc(1);
    check("T6 open bip", bus.bip, 0);
    wait_cyc(19);
    check("T6 bip@19", bus.bip, 0);
    wait_cyc(1);
    check("T6 bip@20", bus.bip, 1);
    bus.sensor_contato = 1'b1;
    wait_cyc(1);
    check("T6 close bip", bus.bip, 0);
    check("T6 close estado", bus.estado, 1);
    bus.sensor_contato = 1'b0;
    wait_cyc(25);
    check("T6 reopen bip", bus.bip, 1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("T6 rst tranca", bus.tranca, 1);
    check("T6 rst bip", bus.bip, 0);
    check("T6 rst estado", bus.estado, 0);
    bus.sensor_contato = 1'b1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(39) == 0) bus.sensor_contato = ~bus.sensor_contato;
      bus.req_interno = ($urandom_range(29) == 0);
      bus.req_senha   = ($urandom_range(19) == 0);
      if ($urandom_range(49) == 0) bus.botao_bloqueio = ~bus.botao_bloqueio;
      if ($urandom_range(99) == 0) bus.timer_trancamento = 7'($urandom_range(6));
      if ($urandom_range(99) == 0) bus.timer_bip = 7'($urandom_range(4));
      if ($urandom_range(59) == 0) bus.bip_habilitado = ~bus.bip_habilitado;
      rst = ($urandom_range(499) == 0);
    end
    @(negedge clk);
    rst             = 1'b0;
    bus.req_interno = 1'b0;
    bus.req_senha   = 1'b0;
    wait_cyc(5);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
